// File: rtl/program_loader_pkg.sv
// program_loader_pkg: state encoding, default geometry and address helper for the boot loader.
package program_loader_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_t;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd0;
    localparam int unsigned DEF_MAX_WORDS = 16384;
    localparam int          LANE_W        = 8;
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction
endpackage

// File: rtl/program_loader_byte_assembler.sv
// byte_assembler: packs four strobed bytes little-endian into a word; word shows the value including the current byte.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              strobe,
    input  logic [LANE_W-1:0] byte_in,
    output logic [31:0]       word,
    output logic              word_done
);
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        lane_d = clr ? 2'd0 : strobe ? lane_q + 2'd1 : lane_q;
        word_d = clr ? 32'd0 : strobe ? word : word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            word_q <= 32'd0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

    assign word      = {byte_in, word_q[31:8]};
    assign word_done = strobe && lane_q == 2'd3;
endmodule

// File: rtl/program_loader.sv
// program_loader: byte-serial boot loader writing a length-prefixed image to instruction memory, then pulsing start.
// Optional trailing XOR checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          word_size = 32,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [LANE_W-1:0]    byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic [word_size-1:0] mem_address,
    output logic [word_size-1:0] mem_write_data,
    output logic                 mem_write,
    output logic                 start,
    output logic [word_size-1:0] start_address,
    output logic                 busy,
    output logic                 error
);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t TAIL = ST_CHK;
    logic [LANE_W-1:0] chk_q, chk_d;
`else
    localparam state_t TAIL = ST_DONE;
`endif
    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [word_size-1:0] len_q, len_d, idx_q, idx_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]          asm_word;
    logic                 asm_done, xfer;

    assign xfer = byte_valid && ready_q;

    byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (state_q == ST_IDLE),
        .strobe   (xfer && (state_q == ST_LEN || state_q == ST_DATA)),
        .byte_in  (byte_in),
        .word     (asm_word),
        .word_done(asm_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk_d   = state_q == ST_IDLE ? '0 : (state_q == ST_DATA && xfer) ? chk_q ^ byte_in : chk_q;
`endif
        case (state_q)
            ST_IDLE:  state_d = load_en ? ST_LEN : ST_IDLE;
            ST_LEN:
                if (asm_done) begin
                    len_d   = asm_word;
                    idx_d   = '0;
                    state_d = asm_word == '0 ? TAIL : asm_word > 32'(MAX_WORDS) ? ST_ERR : ST_DATA;
                end
            ST_DATA:
                if (asm_done) begin
                    wdata_d = asm_word;
                    addr_d  = word_addr(BASE_ADDR, idx_q);
                    state_d = ST_WRITE;
                end
            ST_WRITE: begin
                idx_d   = idx_q + 32'd1;
                state_d = idx_q + 32'd1 == len_q ? TAIL : ST_DATA;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHK:   if (xfer) state_d = byte_in == chk_q ? ST_DONE : ST_ERR;
`endif
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
        ready_d = state_d == ST_LEN || state_d == ST_DATA || state_d == ST_CHK;
    end

    always_comb begin
        mem_write     = state_q == ST_WRITE;
        start         = state_q == ST_DONE;
        start_address = state_q == ST_DONE ? BASE_ADDR : '0;
        busy          = state_q != ST_IDLE;
        error         = state_q == ST_ERR;
    end

    assign byte_ready     = ready_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
endmodule
